// File: rtl/fft_feed_pkg.sv
// Shared types and helpers for the FFT frame feeder.
// Complex words carry the left-justified sample as real and zero as imag.
package fft_feed_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD,
    DONE
  } state_e;

  localparam int unsigned REAL_W = 16;
  localparam int unsigned IMAG_W = 16;
  localparam int unsigned WORD_W = REAL_W + IMAG_W;

  function automatic logic [WORD_W-1:0] pack_sample(
    input logic [REAL_W-1:0] s,
    input int unsigned       w
  );
    logic [REAL_W-1:0] re;
    re = s << (REAL_W - w);
    return {re, {IMAG_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fft_feed_fifo.sv
// Show-ahead sample FIFO: the head entry is visible on rd_data_o
// the cycle after it is written; a write to a full FIFO succeeds with a read.
module fft_feed_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign full_o    = (cnt_q == CNT_FULL);
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_rd = rd_en_i && !empty_o && !flush_i;
  assign do_wr = wr_en_i && (!full_o || do_rd) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// AXI-Stream source framing recorder samples into FFT_LEN-long frames,
// with tlast per frame, zero padding of a partial tail and a frame limit.
module fft_frame_feeder
  import fft_feed_pkg::*;
#(
  parameter int SAMPLE_W    = 8,
  parameter int FFT_LEN     = 2048,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_FRAMES  = 0,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   start_in,
  input  logic [SAMPLE_W-1:0]    sample_in,
  input  logic                   sample_valid_in,
  input  logic                   finish_in,
  output logic [31:0]            m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [FRAME_CNT_W-1:0] frames_done_out,
  output logic                   busy_out,
  output logic                   overflow_out,
  output logic                   done_out
);

  localparam int IW = $clog2(FFT_LEN);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(FFT_LEN - 1);
  localparam logic [FRAME_CNT_W-1:0] FR_MAX = '1;
  localparam logic [FRAME_CNT_W-1:0] FR_LIM = FRAME_CNT_W'(MAX_FRAMES);

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;
  logic                   ovf_q, ovf_d;
  logic                   fin_q, fin_d;

  logic                   flush, push, pop;
  logic [SAMPLE_W-1:0]    head;
  logic                   full, empty;
  logic [CW:0]            count;
  logic                   xfer, last_xfer, lim_hit;
  logic [FRAME_CNT_W-1:0] fr_inc;

  fft_feed_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk_i     (clk_in),
    .rst_ni    (rst_n_in),
    .flush_i   (flush),
    .wr_en_i   (push),
    .wr_data_i (sample_in),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  assign m_tvalid = ((state_q == STREAM) && !empty) ||
                    (state_q == PAD);
  assign m_tdata  = (state_q == STREAM) ?
                    pack_sample(REAL_W'(head), SAMPLE_W) : '0;
  assign m_tlast  = m_tvalid && (idx_q == IDX_LAST);

  assign xfer      = m_tvalid && m_tready;
  assign last_xfer = xfer && m_tlast;
  assign fr_inc    = (frames_q == FR_MAX) ? frames_q
                                          : frames_q + 1'b1;
  assign lim_hit   = (MAX_FRAMES != 0) && (fr_inc == FR_LIM);

  assign frames_done_out = frames_q;
  assign overflow_out    = ovf_q;
  assign busy_out        = (state_q == STREAM) || (state_q == PAD);
  assign done_out        = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    ovf_d    = ovf_q;
    fin_d    = fin_q;
    flush    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          flush    = 1'b1;
          idx_d    = '0;
          frames_d = '0;
          ovf_d    = 1'b0;
          fin_d    = 1'b0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        pop = xfer;
        if (sample_valid_in) begin
          if (full && !xfer) ovf_d = 1'b1;
          else               push  = 1'b1;
        end
        if (finish_in) fin_d = 1'b1;
        if (xfer)      idx_d = idx_q + 1'b1;
        if (last_xfer) frames_d = fr_inc;
        // A frame limit ends the capture even with samples still queued.
        if (last_xfer && lim_hit) begin
          flush   = 1'b1;
          push    = 1'b0;
          state_d = DONE;
        end else if ((fin_q || finish_in) && (count == '0) && !push) begin
          state_d = (idx_q == '0) ? DONE : PAD;
        end
      end
      PAD: begin
        if (xfer) idx_d = idx_q + 1'b1;
        if (last_xfer) begin
          frames_d = fr_inc;
          state_d  = DONE;
        end
      end
      DONE: begin
        fin_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      frames_q <= '0;
      ovf_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frames_q <= frames_d;
      ovf_q    <= ovf_d;
      fin_q    <= fin_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: frame/pad/limit behaviour against a
// queue model of the expected transfer stream.
module tb_fft_frame_feeder;

  localparam int SW  = 8;
  localparam int FL  = 8;
  localparam int FD  = 4;
  localparam int FCW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, fin, sv, rdy;
  logic [SW-1:0] smp;
  logic [31:0]   tdata;
  logic          tvalid, tlast, busy, ovf, done;
  logic [FCW-1:0] frames;

  logic          l_start, l_fin, l_sv, l_rdy;
  logic [SW-1:0] l_smp;
  logic [31:0]   l_tdata;
  logic          l_tvalid, l_tlast, l_busy, l_ovf, l_done;
  logic [FCW-1:0] l_frames;

  fft_frame_feeder #(
    .SAMPLE_W(SW), .FFT_LEN(FL), .FIFO_DEPTH(FD),
    .MAX_FRAMES(0), .FRAME_CNT_W(FCW)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
    .sample_in(smp), .sample_valid_in(sv), .finish_in(fin),
    .m_tdata(tdata), .m_tvalid(tvalid), .m_tready(rdy),
    .m_tlast(tlast), .frames_done_out(frames),
    .busy_out(busy), .overflow_out(ovf), .done_out(done)
  );

  fft_frame_feeder #(
    .SAMPLE_W(SW), .FFT_LEN(FL), .FIFO_DEPTH(FD),
    .MAX_FRAMES(1), .FRAME_CNT_W(FCW)
  ) dut_l (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(l_start),
    .sample_in(l_smp), .sample_valid_in(l_sv), .finish_in(l_fin),
    .m_tdata(l_tdata), .m_tvalid(l_tvalid), .m_tready(l_rdy),
    .m_tlast(l_tlast), .frames_done_out(l_frames),
    .busy_out(l_busy), .overflow_out(l_ovf), .done_out(l_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] got[$];
  logic [32:0] got_l[$];
  logic [32:0] exp_q[$];
  logic [SW-1:0] stim[$];
  int done_cnt = 0;
  int done_cnt_l = 0;
  bit rnd_rdy = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid && rdy) got.push_back({tlast, tdata});
      if (l_tvalid && l_rdy) got_l.push_back({l_tlast, l_tdata});
      if (done) done_cnt++;
      if (l_done) done_cnt_l++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
  endtask

  // Expected stream: each sample left-justified, zero words to fill the
  // last frame, tlast on every FL-th word.
  task automatic build_exp();
    exp_q.delete();
    foreach (stim[i])
      exp_q.push_back({(i % FL) == FL - 1, stim[i], 24'h0});
    while (exp_q.size() % FL != 0)
      exp_q.push_back({(exp_q.size() % FL) == FL - 1, 32'h0});
  endtask

  task automatic run_capture(input string nm, input int maxgap);
    int pushed;
    int guard;
    got.delete();
    done_cnt = 0;
    if (!rnd_rdy) rdy = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    pushed = 0;
    foreach (stim[i]) begin
      guard = 0;
      while (pushed - got.size() >= FD - 1 && guard < 200) begin
        cyc(); guard++;
      end
      sv = 1'b1; smp = stim[i]; cyc(); sv = 1'b0;
      pushed++;
      repeat ($urandom_range(0, maxgap)) cyc();
    end
    fin = 1'b1; cyc(); fin = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin
      cyc(); guard++;
    end
    repeat (2) cyc();
    build_exp();
    n_cmp++;
    if (done_cnt !== 1) begin
      n_bad++;
      $display("FAIL %s.done_pulses: got %0d want 1", nm, done_cnt);
    end
    n_cmp++;
    if (got.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s.count: got %0d want %0d", nm, got.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got.size()) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL %s.word[%0d]: got %h want %h", nm, i, got[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (frames !== FCW'(exp_q.size() / FL)) begin
      n_bad++;
      $display("FAIL %s.frames: got %0d want %0d", nm, frames, exp_q.size() / FL);
    end
    n_cmp++;
    if ({ovf, busy, tvalid} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s.ovf_busy_valid: got %b want 000", nm, {ovf, busy, tvalid});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    n_cmp++;
    if ({tvalid, tlast, tdata, frames, busy, ovf, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want 0", {tvalid, tlast, tdata, frames, busy, ovf, done});
    end
    @(negedge clk); rst_n = 1'b1;
    cyc();
    n_cmp++;
    if ({tvalid, tlast, tdata, frames, busy, ovf, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_release: got %h want 0", {tvalid, tlast, tdata, frames, busy, ovf, done});
    end
    rdy = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sv = 1'b1; smp = SW'(k); cyc(); sv = 1'b0;
    end
    rdy = 1'b1;
    repeat (3) cyc();
    rdy = 1'b0;
    n_cmp++;
    if ({ovf, tvalid, tlast, tdata} !== {3'b110, 8'd4, 24'h0}) begin
      n_bad++;
      $display("FAIL midframe_pre: got %h want %h", {ovf, tvalid, tlast, tdata}, {3'b110, 8'd4, 24'h0});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tvalid, tlast, tdata, frames, busy, ovf, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_midframe: got %h want 0", {tvalid, tlast, tdata, frames, busy, ovf, done});
    end
    @(negedge clk); rst_n = 1'b1;
    cyc();
    stim.delete();
    for (int k = 0; k < FL; k++) stim.push_back(SW'($urandom));
    run_capture("post_reset", 0);
  endtask

  task automatic test_full_frames();
    stim.delete();
    for (int k = 1; k <= 16; k++) stim.push_back(SW'(k));
    run_capture("full", 0);
  endtask

  task automatic test_partial_pad();
    stim.delete();
    for (int k = 0; k < 11; k++) stim.push_back(SW'($urandom));
    run_capture("partial", 0);
  endtask

  task automatic test_overflow_stall();
    int guard;
    got.delete();
    done_cnt = 0;
    rdy = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sv = 1'b1; smp = SW'(8'h11 + k); cyc(); sv = 1'b0;
    end
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf.flag: got %b want 1", ovf);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({tvalid, tlast, tdata} !== {2'b10, 8'h11, 24'h0}) begin
        n_bad++;
        $display("FAIL ovf.stall[%0d]: got %h want %h", k, {tvalid, tlast, tdata}, {2'b10, 8'h11, 24'h0});
      end
      cyc();
    end
    rdy = 1'b1;
    fin = 1'b1; cyc(); fin = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 100) begin
      cyc(); guard++;
    end
    repeat (2) cyc();
    stim.delete();
    for (int k = 0; k < FD; k++) stim.push_back(SW'(8'h11 + k));
    build_exp();
    n_cmp++;
    if (got.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL ovf.count: got %0d want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got.size()) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL ovf.word[%0d]: got %h want %h", i, got[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if ({done_cnt == 1, ovf, frames} !== {2'b11, 16'd1}) begin
      n_bad++;
      $display("FAIL ovf.end: got %h want %h", {done_cnt == 1, ovf, frames}, {2'b11, 16'd1});
    end
  endtask

  task automatic test_finish_after_tlast();
    got.delete();
    done_cnt = 0;
    rdy = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < FL; k++) begin
      sv = 1'b1; smp = SW'($urandom); cyc(); sv = 1'b0;
    end
    cyc();
    n_cmp++;
    if ({tvalid, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL edge.pre: got %b want 01", {tvalid, busy});
    end
    fin = 1'b1; cyc(); fin = 1'b0;
    n_cmp++;
    if ({done, busy, tvalid} !== 3'b100) begin
      n_bad++;
      $display("FAIL edge.done_now: got %b want 100", {done, busy, tvalid});
    end
    cyc();
    n_cmp++;
    if ({done, done_cnt, got.size(), frames} !== {1'b0, 32'd1, 32'd8, 16'd1}) begin
      n_bad++;
      $display("FAIL edge.after: got done=%b pulses=%0d words=%0d frames=%0d want 0/1/8/1",
               done, done_cnt, got.size(), frames);
    end
    if (got.size() == FL) begin
      n_cmp++;
      if (got[FL-1][32] !== 1'b1) begin
        n_bad++;
        $display("FAIL edge.tlast: got %b want 1", got[FL-1][32]);
      end
    end
  endtask

  task automatic test_frame_limit();
    logic [SW-1:0] v[$];
    got_l.delete();
    done_cnt_l = 0;
    l_rdy = 1'b1;
    l_start = 1'b1; cyc(); l_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      v.push_back(SW'($urandom));
      l_sv = 1'b1; l_smp = v[k]; cyc(); l_sv = 1'b0;
    end
    repeat (10) cyc();
    n_cmp++;
    if (got_l.size() !== FL) begin
      n_bad++;
      $display("FAIL limit.count: got %0d want %0d", got_l.size(), FL);
    end
    for (int k = 0; k < FL; k++) begin
      if (k < got_l.size()) begin
        n_cmp++;
        if (got_l[k] !== {k == FL - 1, v[k], 24'h0}) begin
          n_bad++;
          $display("FAIL limit.word[%0d]: got %h want %h", k, got_l[k], {k == FL - 1, v[k], 24'h0});
        end
      end
    end
    n_cmp++;
    if ({done_cnt_l == 1, l_frames, l_busy, l_ovf, l_tvalid} !== {1'b1, 16'd1, 3'b000}) begin
      n_bad++;
      $display("FAIL limit.end: got pulses=%0d frames=%0d busy=%b ovf=%b valid=%b",
               done_cnt_l, l_frames, l_busy, l_ovf, l_tvalid);
    end
  endtask

  task automatic test_random_backpressure();
    stim.delete();
    for (int k = 0; k < 21; k++) stim.push_back(SW'($urandom));
    rnd_rdy = 1'b1;
    run_capture("random", 2);
    rnd_rdy = 1'b0;
    rdy = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; fin = 1'b0; sv = 1'b0; smp = '0; rdy = 1'b1;
    l_start = 1'b0; l_fin = 1'b0; l_sv = 1'b0; l_smp = '0; l_rdy = 1'b1;
    test_reset();
    test_full_frames();
    test_partial_pad();
    test_overflow_stall();
    test_finish_after_tlast();
    test_frame_limit();
    test_random_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
